cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the single 16-bit Common Data Bus between the Tomasulo functional units: adder and multiplier reservation-station outputs.
- Each unit holds a finished result (tag + value) and requests the bus. The arbiter grants one requester per cycle, round-robin.
- The granted result is registered onto the CDB for one cycle, where it is broadcast to reservation stations and the register file (reg1/reg2).
- Sits between the functional units and the CDB wire in the pratica3 top level.

Parameters:
- N_REQ, 4, number of requesters (index 0-1 adders, 2-3 multipliers).
- DATA_W, 16, result width.
- TAG_W, 3, reservation-station tag width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-unit result-ready request; held high until granted.
- req_tag  in  N_REQ*TAG_W  packed tags; slice i belongs to requester i.
- req_data  in  N_REQ*DATA_W  packed results; slice i belongs to requester i.
- stall  in  1  CDB consumer busy; no grant issued while high.
- flush  in  1  discard in-flight broadcast; no grant this cycle.
- grant  out  N_REQ  one-hot, combinational; requester i's result is accepted at this edge.
- cdb_valid  out  1  registered; CDB carries a valid broadcast.
- cdb_tag  out  TAG_W  registered broadcast tag.
- cdb_data  out  DATA_W  registered broadcast value.
- cdb_src  out  2  registered index of the unit that produced the broadcast.

Behaviour:
- Reset (synchronous, on a clock edge with reset=1):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - rr_ptr=N_REQ-1, so requester 0 has first priority.
  - grant is forced to 0 while reset is high.
- Arbitration (combinational):
  - If stall=0, flush=0 and reset=0, grant the first requester with req=1, searching from index (rr_ptr+1) mod N_REQ upward with wrap-around.
  - grant has at most one bit set.
  - If no requester has req=1, grant=0.
- Registration at the edge where grant[i]=1:
  - cdb_valid<=1, cdb_tag<=req_tag[i], cdb_data<=req_data[i], cdb_src<=i, rr_ptr<=i.
  - Latency: request accepted in cycle t is visible on the CDB in cycle t+1 for exactly one cycle.
- Edge with no grant: cdb_valid<=0, and cdb_tag/cdb_data/cdb_src are also cleared to 0.
- Requester protocol:
  - A requester drops req (or presents its next result) in the cycle after its grant.
  - Tag and data must be stable while req=1 and grant is low.
  - The arbiter does not latch non-granted requests.
- Back-to-back operation: one broadcast per cycle, sustained while requests remain.
- Fairness: a continuously requesting unit waits at most N_REQ-1 grant cycles.
- stall=1: no grant, cdb_valid<=0 next cycle, rr_ptr unchanged; requests remain pending.
- flush=1: no grant, cdb_valid<=0 next cycle, rr_ptr unchanged.
- Priority of simultaneous controls: reset > flush > stall.
- A single requester is granted every cycle it requests; rr_ptr moving to itself does not block it.
- Reset mid-broadcast: cdb_valid drops on the reset edge, and the broadcast is lost. Upstream units are also reset.

Decomposition:
- Shared package tomasulo_pkg holds:
  - DATA_W and TAG_W.
  - The requester index constants ADD0=0, ADD1=1, MUL0=2, MUL1=3.
  - The cdb_t struct {valid, tag, data, src}, reused by the reservation stations and the register file.
- One sub-module, rr_picker: combinational round-robin priority select.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and the encoded index.
- The cdb_arbiter top holds the pointer and the CDB output registers.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, req=0000 -> grant=0000, cdb_valid=0, cdb_tag=0, cdb_data=0 in every cycle.
- Single request: req=0100, tag=3'd5, data=16'h00AB in cycle t -> grant=0100 in t; in t+1 cdb_valid=1, cdb_tag=5, cdb_data=00AB, cdb_src=2; cdb_valid=0 in t+2 after req drops.
- Round-robin: req=1111 held, each unit dropping req one cycle after its grant and re-raising it the following cycle -> grant sequence 0001,0010,0100,1000,0001; cdb_src follows 0,1,2,3,0 one cycle later.
- Stall: req=0011 with stall=1 for 3 cycles -> grant=0000 and cdb_valid=0 throughout; after stall drops, requester 0 is granted first, then 1.
- Flush with reset precedence: req=1000 with flush=1 -> no grant, cdb_valid=0. Then assert reset and flush together with req=1000 -> reset result (rr_ptr=3, outputs 0). Next cycle with req=0001 only -> grant=0001.
- Wrap-around pointer: grant 3 alone, then req=1001 -> grant=0001 (0 follows 3), then grant=1000.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo widths, requester indices and CDB broadcast type
package tomasulo_pkg;

   localparam int DATA_W = 16;
   localparam int TAG_W  = 3;

   localparam int ADD0 = 0;
   localparam int ADD1 = 1;
   localparam int MUL0 = 2;
   localparam int MUL1 = 3;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic [1:0]        src;
   } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rtl/cdb_arbiter_rr_picker.sv - combinational round-robin select starting after rr_ptr
module rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] rr_ptr,
   input  logic             enable,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   int  j;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      if (enable) begin
         // offset N wraps back to rr_ptr itself, so a lone requester is never blocked
         for (int k = 1; k <= N; k++) begin
            j = (int'(rr_ptr) + k) % N;
            if (!found && req[j]) begin
               found    = 1'b1;
               grant[j] = 1'b1;
               idx      = IDX_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered Common Data Bus
module cdb_arbiter
   import tomasulo_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int P_DATA_W = DATA_W,
   parameter int P_TAG_W  = TAG_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*P_TAG_W-1:0]  req_tag,
   input  logic [N_REQ*P_DATA_W-1:0] req_data,
   input  logic                      stall,
   input  logic                      flush,
   output logic [N_REQ-1:0]          grant,
   output logic                      cdb_valid,
   output logic [P_TAG_W-1:0]        cdb_tag,
   output logic [P_DATA_W-1:0]       cdb_data,
   output logic [1:0]                cdb_src
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] win_idx;
   logic             enable;

   // reset outranks flush, which outranks stall; any of them suppresses the grant
   assign enable = !reset && !flush && !stall;

   rr_picker #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr),
      .enable (enable),
      .grant  (grant),
      .idx    (win_idx)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_src   <= '0;
         rr_ptr    <= IDX_W'(N_REQ - 1);
      end else if (|grant) begin
         cdb_valid <= 1'b1;
         cdb_tag   <= req_tag[int'(win_idx)*P_TAG_W +: P_TAG_W];
         cdb_data  <= req_data[int'(win_idx)*P_DATA_W +: P_DATA_W];
         cdb_src   <= 2'(win_idx);
         rr_ptr    <= win_idx;
      end else begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_src   <= '0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
   import tomasulo_pkg::*;

   localparam int N_REQ = 4;

   logic                      clock = 1'b0;
   logic                      reset;
   logic [N_REQ-1:0]          req;
   logic [N_REQ*TAG_W-1:0]    req_tag;
   logic [N_REQ*DATA_W-1:0]   req_data;
   logic                      stall;
   logic                      flush;
   logic [N_REQ-1:0]          grant;
   logic                      cdb_valid;
   logic [TAG_W-1:0]          cdb_tag;
   logic [DATA_W-1:0]         cdb_data;
   logic [1:0]                cdb_src;

   int    checks = 0;
   int    errors = 0;
   cdb_t  exp_q[$];
   string prev_name = "none";

   always #5 clock = ~clock;

   cdb_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .stall     (stall),
      .flush     (flush),
      .grant     (grant),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   task automatic check_cdb();
      cdb_t exp;
      cdb_t obs;
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         obs = {cdb_valid, cdb_tag, cdb_data, cdb_src};
         checks++;
         assert (obs === exp) else begin
            errors++;
            $error("FAIL cdb_after_%s observed=%h expected=%h", prev_name, obs, exp);
         end
      end
   endtask

   task automatic step(input logic [N_REQ-1:0] rq, input logic st, input logic fl,
                       input logic rs, input logic [N_REQ-1:0] eg, input string name);
      cdb_t exp;
      @(negedge clock);
      check_cdb();
      req   = rq;
      stall = st;
      flush = fl;
      reset = rs;
      #1;
      checks++;
      assert (grant === eg) else begin
         errors++;
         $error("FAIL grant_%s observed=%b expected=%b", name, grant, eg);
      end
      exp = '0;
      if (!rs) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (eg[i]) begin
               exp.valid = 1'b1;
               exp.tag   = req_tag[i*TAG_W +: TAG_W];
               exp.data  = req_data[i*DATA_W +: DATA_W];
               exp.src   = 2'(i);
            end
         end
      end
      exp_q.push_back(exp);
      prev_name = name;
   endtask

   initial begin
      reset    = 1'b1;
      req      = '0;
      stall    = 1'b0;
      flush    = 1'b0;
      req_tag  = {3'd7, 3'd6, 3'd1, 3'd2};
      req_data = {16'hD003, 16'hC002, 16'hB001, 16'hA000};

      step(4'b0000, 0, 0, 1, 4'b0000, "reset0");
      step(4'b0000, 0, 0, 1, 4'b0000, "reset1");
      step(4'b1111, 0, 0, 1, 4'b0000, "reset_req");
      step(4'b0000, 0, 0, 0, 4'b0000, "idle");

      // single request from MUL0 with its own tag and value
      req_tag[MUL0*TAG_W +: TAG_W]    = 3'd5;
      req_data[MUL0*DATA_W +: DATA_W] = 16'h00AB;
      step(4'b0100, 0, 0, 0, 4'b0100, "single");
      step(4'b0000, 0, 0, 0, 4'b0000, "single_drop");
      step(4'b0000, 0, 0, 0, 4'b0000, "single_idle");

      step(4'b0000, 0, 0, 1, 4'b0000, "rr_reset");
      step(4'b1111, 0, 0, 0, 4'b0001, "rr0");
      step(4'b1110, 0, 0, 0, 4'b0010, "rr1");
      step(4'b1101, 0, 0, 0, 4'b0100, "rr2");
      step(4'b1011, 0, 0, 0, 4'b1000, "rr3");
      step(4'b0111, 0, 0, 0, 4'b0001, "rr4");
      step(4'b1110, 0, 0, 0, 4'b0010, "rr5");

      step(4'b0000, 0, 0, 1, 4'b0000, "stall_reset");
      step(4'b0011, 1, 0, 0, 4'b0000, "stall0");
      step(4'b0011, 1, 0, 0, 4'b0000, "stall1");
      step(4'b0011, 1, 0, 0, 4'b0000, "stall2");
      step(4'b0011, 0, 0, 0, 4'b0001, "unstall0");
      step(4'b0010, 0, 0, 0, 4'b0010, "unstall1");
      step(4'b1111, 1, 0, 0, 4'b0000, "stall_keep_ptr");
      step(4'b1111, 0, 0, 0, 4'b0100, "after_stall_ptr");

      step(4'b1000, 0, 1, 0, 4'b0000, "flush");
      step(4'b1000, 1, 1, 0, 4'b0000, "flush_stall");
      step(4'b1000, 0, 1, 1, 4'b0000, "reset_flush");
      step(4'b0001, 0, 0, 0, 4'b0001, "post_reset_flush");

      step(4'b1000, 0, 0, 0, 4'b1000, "wrap_solo3");
      step(4'b1001, 0, 0, 0, 4'b0001, "wrap_to0");
      step(4'b1000, 0, 0, 0, 4'b1000, "wrap_back3");
      step(4'b1000, 0, 0, 0, 4'b1000, "solo_repeat");
      step(4'b0000, 0, 0, 0, 4'b0000, "drain");

      @(negedge clock);
      check_cdb();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
